// File: rtl/array_reader_pkg.sv
// array_reader_pkg
//   Shared types and width helpers for the array read sequencer.
//   state_e    : sequencer states (IDLE, READ, DRAIN)
//   idx_width  : bits needed to address height entries (at least 1)
//   cnt_width  : bits needed to hold a count 0..height
package array_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned height);
        return (height < 2) ? 1 : $clog2(height);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned height);
        return $clog2(height + 1);
    endfunction

endpackage

// File: rtl/array_reader_wrap_counter.sv
// array_reader_wrap_counter
//   Modulo-n_p up-counter with synchronous load and count enable.
//   Counts n_p-1 -> 0 with no gap cycle; load has priority over enable.
// Ports:
//   clk_i      : clock
//   reset_i    : synchronous active-high reset, count returns to 0
//   load_i     : load load_val_i into the counter
//   load_val_i : value to load (must be < n_p)
//   en_i       : advance by one, wrapping at n_p-1
//   count_o    : current count
module array_reader_wrap_counter
    import array_reader_pkg::*;
#(
    parameter int unsigned n_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         load_i,
    input  logic [idx_width(n_p)-1:0]    load_val_i,
    input  logic                         en_i,
    output logic [idx_width(n_p)-1:0]    count_o
);

    localparam int unsigned cw_lp = idx_width(n_p);
    localparam logic [cw_lp-1:0] max_lp = cw_lp'(n_p - 1);

    logic [cw_lp-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i) begin
            count_q <= (count_q == max_lp) ? '0 : count_q + cw_lp'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/array_reader.sv
// array_reader
//   Read-side sequencer for the array storage block. Accepts a burst
//   command (first index, length), walks the array's combinational read
//   port modulo height_p and streams words over valid/ready at full rate.
//   Optional macro ARRAY_READER_BYPASS_EN forwards a same-cycle write on
//   the snoop port to the output register (read-after-write returns the
//   new value); when undefined the snoop port is ignored.
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   start_v_i/start_ready_o : burst command handshake
//   first_i, len_i          : first index (< height_p), word count (0..height_p)
//   index_o, data_i         : array read index and combinational read data
//   snoop_w_v_i/_index_i/_data_i : copy of the array write port
//   v_o, data_o, last_o, ready_i : output word stream
//   done_o                  : one-cycle pulse when a burst completes
module array_reader
    import array_reader_pkg::*;
#(
    parameter int unsigned width_p  = 8,
    parameter int unsigned height_p = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              start_v_i,
    output logic                              start_ready_o,
    input  logic [idx_width(height_p)-1:0]    first_i,
    input  logic [cnt_width(height_p)-1:0]    len_i,
    output logic [idx_width(height_p)-1:0]    index_o,
    input  logic [width_p-1:0]                data_i,
    input  logic                              snoop_w_v_i,
    input  logic [idx_width(height_p)-1:0]    snoop_index_i,
    input  logic [width_p-1:0]                snoop_data_i,
    output logic                              v_o,
    output logic [width_p-1:0]                data_o,
    output logic                              last_o,
    input  logic                              ready_i,
    output logic                              done_o
);

    localparam int unsigned lw_lp = cnt_width(height_p);

    state_e             state_q, state_n;
    logic [lw_lp-1:0]   remaining_q;
    logic               v_q, last_q, done_q;
    logic [width_p-1:0] data_q;
    logic [width_p-1:0] load_data;
    logic               idx_load, idx_en, load, consume;

    array_reader_wrap_counter #(
        .n_p (height_p)
    ) u_index (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (idx_load),
        .load_val_i (first_i),
        .en_i       (idx_en),
        .count_o    (index_o)
    );

    always_comb begin
        state_n       = state_q;
        start_ready_o = 1'b0;
        idx_load      = 1'b0;
        idx_en        = 1'b0;
        load          = 1'b0;
        consume       = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_ready_o = 1'b1;
                if (start_v_i && (len_i != '0)) begin
                    idx_load = 1'b1;
                    state_n  = READ;
                end
            end
            READ: begin
                // Output register is free when empty or being drained this cycle.
                load = ~v_q | ready_i;
                if (load) begin
                    idx_en = 1'b1;
                    if (remaining_q == lw_lp'(1)) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (v_q && ready_i) begin
                    consume = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef ARRAY_READER_BYPASS_EN
    always_comb begin
        load_data = data_i;
        if (snoop_w_v_i && (snoop_index_i == index_o)) begin
            load_data = snoop_data_i;
        end
    end
`else
    // Array read is pre-write, so the old value is returned on a collision.
    assign load_data = data_i;
    logic unused_snoop;
    assign unused_snoop = &{1'b0, snoop_w_v_i, snoop_index_i, snoop_data_i};
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            v_q         <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_n;
            done_q  <= 1'b0;
            if (start_v_i && start_ready_o) begin
                if (len_i == '0) begin
                    done_q <= 1'b1;
                end else begin
                    remaining_q <= len_i;
                end
            end
            if (load) begin
                data_q      <= load_data;
                v_q         <= 1'b1;
                last_q      <= (remaining_q == lw_lp'(1));
                remaining_q <= remaining_q - lw_lp'(1);
            end
            if (consume) begin
                v_q    <= 1'b0;
                last_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!reset_i && start_v_i && start_ready_o) begin
            assert ((32'(first_i) < height_p) && (32'(len_i) <= height_p))
                else $error("array_reader: illegal command first=%0d len=%0d", first_i, len_i);
        end
    end
`endif

    assign v_o    = v_q;
    assign data_o = data_q;
    assign last_o = last_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_array_reader.sv
// tb_array_reader
//   Self-checking bench for array_reader (height 4, width 8). The array is
//   modelled in the bench; expected words are derived from a model memory
//   and circular index arithmetic. Set ARRAY_READER_BYPASS_EN for the
//   forwarding variant.
module tb_array_reader;

    localparam int H  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
    localparam int LW = 3;

`ifdef ARRAY_READER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start_v;
    logic          start_ready;
    logic [IW-1:0] first;
    logic [LW-1:0] len;
    logic [IW-1:0] index;
    logic [W-1:0]  data_arr;
    logic          snoop_w_v;
    logic [IW-1:0] snoop_index;
    logic [W-1:0]  snoop_data;
    logic          v;
    logic [W-1:0]  data_out;
    logic          last;
    logic          ready;
    logic          done;

    logic [W-1:0]  mem [H];
    logic [W-1:0]  model_mem [H];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    array_reader #(
        .width_p  (W),
        .height_p (H)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_v_i     (start_v),
        .start_ready_o (start_ready),
        .first_i       (first),
        .len_i         (len),
        .index_o       (index),
        .data_i        (data_arr),
        .snoop_w_v_i   (snoop_w_v),
        .snoop_index_i (snoop_index),
        .snoop_data_i  (snoop_data),
        .v_o           (v),
        .data_o        (data_out),
        .last_o        (last),
        .ready_i       (ready),
        .done_o        (done)
    );

    // Behavioural array: combinational read of the pre-write contents.
    assign data_arr = mem[index];
    always @(posedge clk) if (snoop_w_v) mem[snoop_index] <= snoop_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int idx, input logic [W-1:0] val);
        snoop_index = IW'(idx);
        snoop_data  = val;
        snoop_w_v   = 1'b1;
        tick();
        snoop_w_v   = 1'b0;
        model_mem[idx] = val;
    endtask

    // Ready held high: checks exact cycle timing, index walk and an
    // optional write landing in cycle wr_cyc.
    task automatic full_rate(input int f, input int n, input int wr_cyc,
                             input int wr_idx, input logic [W-1:0] wr_dat);
        logic [W-1:0] exp_q[$];
        logic [W-1:0] snap [H];
        logic [W-1:0] val;
        int idx;
        for (int i = 0; i < H; i++) snap[i] = model_mem[i];
        for (int k = 0; k < n; k++) begin
            idx = (f + k) % H;
            val = snap[idx];
            if (k == wr_cyc && idx == wr_idx && BYP) val = wr_dat;
            exp_q.push_back(val);
            if (k == wr_cyc) snap[wr_idx] = wr_dat;
        end
        ready   = 1'b1;
        first   = IW'(f);
        len     = LW'(n);
        start_v = 1'b1;
        chk("start_ready_idle", start_ready, 1);
        tick();
        start_v = 1'b0;
        if (n == 0) begin
            chk("len0_done", done, 1);
            chk("len0_v", v, 0);
            chk("len0_start_ready", start_ready, 1);
            tick();
            chk("len0_done_clear", done, 0);
            chk("len0_v_after", v, 0);
            return;
        end
        for (int c = 0; c <= n; c++) begin
            if (c > 0) begin
                chk("fr_v", v, 1);
                chk("fr_data", data_out, exp_q[c-1]);
                chk("fr_last", last, (c == n) ? 1 : 0);
            end else begin
                chk("fr_first_v", v, 0);
            end
            if (c < n) chk("fr_index", index, (f + c) % H);
            chk("fr_start_ready_busy", start_ready, 0);
            chk("fr_done_early", done, 0);
            if (c == wr_cyc) begin
                snoop_index = IW'(wr_idx);
                snoop_data  = wr_dat;
                snoop_w_v   = 1'b1;
            end
            tick();
            snoop_w_v = 1'b0;
        end
        if (wr_cyc >= 0) model_mem[wr_idx] = wr_dat;
        chk("fr_done", done, 1);
        chk("fr_v_after", v, 0);
        chk("fr_last_after", last, 0);
        chk("fr_start_ready_back", start_ready, 1);
        tick();
        chk("fr_done_pulse", done, 0);
    endtask

    // Ready driven by a pattern (bit c = ready in cycle c, then high);
    // optional noise commands while busy must be ignored.
    task automatic stall_burst(input int f, input int n, input logic [31:0] pat, input bit noise);
        logic [W-1:0] exp_q[$];
        logic [W-1:0] held;
        logic [W-1:0] e;
        bit hold_valid;
        bit done_seen;
        int cyc;
        for (int k = 0; k < n; k++) exp_q.push_back(model_mem[(f + k) % H]);
        ready   = 1'b1;
        first   = IW'(f);
        len     = LW'(n);
        start_v = 1'b1;
        chk("sb_start_ready", start_ready, 1);
        tick();
        start_v    = 1'b0;
        hold_valid = 1'b0;
        done_seen  = 1'b0;
        held       = '0;
        cyc        = 0;
        while (cyc < 80) begin
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            if (hold_valid) begin
                chk("stall_v_hold", v, 1);
                chk("stall_data_hold", data_out, held);
            end
            ready = (cyc < 32) ? pat[cyc] : 1'b1;
            if (noise) begin
                start_v = 1'($urandom_range(0, 1));
                first   = IW'($urandom_range(0, H - 1));
                len     = LW'($urandom_range(0, H));
            end
            if (v) chk("sb_start_ready_busy", start_ready, 0);
            if (v && ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", data_out, e);
                    chk("sb_last", last, (exp_q.size() == 0) ? 1 : 0);
                end
                hold_valid = 1'b0;
            end else if (v) begin
                hold_valid = 1'b1;
                held       = data_out;
            end else begin
                hold_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        start_v = 1'b0;
        ready   = 1'b1;
        chk("sb_done_seen", done_seen, 1);
        chk("sb_words_left", exp_q.size(), 0);
        chk("sb_v_after", v, 0);
        chk("sb_start_ready_back", start_ready, 1);
        tick();
        chk("sb_done_pulse", done, 0);
    endtask

    initial begin
        reset       = 1'b1;
        start_v     = 1'b0;
        first       = '0;
        len         = '0;
        ready       = 1'b0;
        snoop_w_v   = 1'b0;
        snoop_index = '0;
        snoop_data  = '0;

        write_mem(0, 8'h11);
        write_mem(1, 8'h22);
        write_mem(2, 8'h33);
        write_mem(3, 8'h44);
        tick();

        chk("rst_v", v, 0);
        chk("rst_last", last, 0);
        chk("rst_done", done, 0);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_index", index, 0);
        chk("rst_data", data_out, 0);
        reset = 1'b0;
        tick();

        // Full burst, then wrap walk, then empty burst.
        full_rate(0, 4, -1, 0, 8'h00);
        full_rate(3, 3, -1, 0, 8'h00);
        full_rate(1, 0, -1, 0, 8'h00);

        // Back-pressure for two cycles after the first beat.
        stall_burst(1, 3, 32'hFFFF_FFF9, 1'b0);

        // Reset after two beats of four.
        ready   = 1'b1;
        first   = 2'd0;
        len     = 3'd4;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        tick();
        tick();
        chk("mid_beat2", data_out, 8'h22);
        reset = 1'b1;
        tick();
        chk("mid_rst_v", v, 0);
        chk("mid_rst_start_ready", start_ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_last", last, 0);
        chk("mid_rst_index", index, 0);
        chk("mid_rst_data", data_out, 0);
        reset = 1'b0;
        tick();
        chk("mid_rst_no_done", done, 0);
        chk("mid_rst_v_idle", v, 0);
        stall_burst(2, 4, 32'hFFFF_FFFF, 1'b0);

        // Same-cycle write to the index being read.
        full_rate(0, 4, 2, 2, 8'h99);
        write_mem(2, 8'h33);

        // Randomized bursts, random back-pressure and ignored commands.
        for (int r = 0; r < 30; r++) begin
            if (r % 5 == 0) write_mem($urandom_range(0, H - 1), 8'($urandom));
            stall_burst($urandom_range(0, H - 1), $urandom_range(0, H),
                        $urandom, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
